// File: rtl/jaxa_pio_pkg.sv
// jaxa_pio_pkg: register map and status bit layout shared by the PIO
// controller and its pulse timer.
package jaxa_pio_pkg;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_SET        = 3'd1;
  localparam logic [2:0] ADDR_CLEAR      = 3'd2;
  localparam logic [2:0] ADDR_PULSE_MASK = 3'd3;
  localparam logic [2:0] ADDR_IN_DATA    = 3'd4;
  localparam logic [2:0] ADDR_EDGE_CAP   = 3'd5;
  localparam logic [2:0] ADDR_IRQ_MASK   = 3'd6;
  localparam logic [2:0] ADDR_STATUS     = 3'd7;

  // STATUS register: bit index of the shared pulse-timer busy flag
  localparam int STATUS_BUSY_BIT = 0;

endpackage

// File: rtl/jaxa_pio_pulse_timer.sv
// jaxa_pio_pulse_timer: shared down-counter for pulse-mode output bits.
// A trigger loads PULSE_LEN-1 and sets busy; expire is high for the single
// cycle in which busy is set and the count has reached zero, so the owner
// clears its pulse bits on that same edge. A trigger always wins over
// expiry, which makes a retrigger on the expiry edge a clean reload.
module jaxa_pio_pulse_timer #(
  parameter int PULSE_LEN = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  output logic expire,
  output logic busy
);

  localparam int CNT_W = $clog2(PULSE_LEN) + 1;
  localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(PULSE_LEN - 1);

  logic [CNT_W-1:0] count_reg;
  logic             busy_reg;

  assign expire = busy_reg && (count_reg == '0);
  assign busy   = busy_reg;

  // Load on trigger, count down while busy, drop busy on expiry
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      busy_reg  <= 1'b0;
    end else if (trigger) begin
      count_reg <= LOAD_VALUE;
      busy_reg  <= 1'b1;
    end else if (expire) begin
      busy_reg  <= 1'b0;
    end else if (busy_reg) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/jaxa_pio_ctrl.sv
// jaxa_pio_ctrl: WIDTH-bit Avalon-MM PIO slave with atomic set/clear,
// per-bit auto-clearing pulse mode (shared timer), a synchronised input
// port with rising-edge capture (W1C), and an optional interrupt.
// Build option: define JAXA_PIO_IRQ_EN to implement IRQ_MASK and irq;
// without it IRQ_MASK reads 0 and irq is tied low.
import jaxa_pio_pkg::*;

module jaxa_pio_ctrl #(
  parameter int               WIDTH       = 8,
  parameter int               PULSE_LEN   = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic             unused_wd_bits;

  logic [WIDTH-1:0] out_reg, out_next, out_cleared;
  logic [WIDTH-1:0] pulse_mask_reg;
  logic             trigger;
  logic             expire;
  logic             pulse_busy;

  logic [WIDTH-1:0] sync1_reg, sync2_reg, sync3_reg;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] edge_cap_reg, edge_cap_next;
  logic [WIDTH-1:0] irq_mask_rd;
  logic             w1c_en;

  logic [31:0]      rd_word;

  assign wr_en          = chipselect && !write_n;
  assign wd             = writedata[WIDTH-1:0];
  assign unused_wd_bits = ^writedata;
  assign w1c_en         = wr_en && (address == ADDR_EDGE_CAP);

  // Next output value: the timer's expiry clear applies first, then any write
  always_comb begin
    out_cleared = out_reg & ~(expire ? pulse_mask_reg : '0);
    out_next    = out_cleared;
    if (wr_en) begin
      case (address)
        ADDR_DATA:  out_next = wd;
        ADDR_SET:   out_next = out_cleared | wd;
        ADDR_CLEAR: out_next = out_cleared & ~wd;
        default:    out_next = out_cleared;
      endcase
    end
    trigger = wr_en && ((address == ADDR_DATA) || (address == ADDR_SET)) &&
              (|(out_next & pulse_mask_reg));
  end

  // Output and pulse-mask registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg        <= RESET_VALUE;
      pulse_mask_reg <= '0;
    end else begin
      out_reg <= out_next;
      if (wr_en && (address == ADDR_PULSE_MASK))
        pulse_mask_reg <= wd;
    end
  end

  assign out_port = out_reg;

  jaxa_pio_pulse_timer #(
    .PULSE_LEN (PULSE_LEN)
  ) u_pulse_timer (
    .clk     (clk),
    .reset   (reset),
    .trigger (trigger),
    .expire  (expire),
    .busy    (pulse_busy)
  );

  // Two-flop synchroniser plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      sync3_reg <= '0;
    end else begin
      sync1_reg <= in_port;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  // Per-bit capture: a rising edge sets the bit and beats a same-edge W1C
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
    assign rise[gi]          = sync2_reg[gi] & ~sync3_reg[gi];
    assign edge_cap_next[gi] = rise[gi] | (edge_cap_reg[gi] & ~(w1c_en & wd[gi]));
  end

  // Edge capture register
  always_ff @(posedge clk) begin
    if (reset)
      edge_cap_reg <= '0;
    else
      edge_cap_reg <= edge_cap_next;
  end

`ifdef JAXA_PIO_IRQ_EN
  logic [WIDTH-1:0] irq_mask_reg;
  logic             irq_reg;

  // Interrupt mask and registered interrupt request
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      if (wr_en && (address == ADDR_IRQ_MASK))
        irq_mask_reg <= wd;
      irq_reg <= |(edge_cap_reg & irq_mask_reg);
    end
  end

  assign irq_mask_rd = irq_mask_reg;
  assign irq         = irq_reg;
`else
  assign irq_mask_rd = '0;
  assign irq         = 1'b0;
`endif

  // Combinational read mux, zero-extended above WIDTH, no side effects
  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_DATA:       rd_word[WIDTH-1:0]      = out_reg;
      ADDR_PULSE_MASK: rd_word[WIDTH-1:0]      = pulse_mask_reg;
      ADDR_IN_DATA:    rd_word[WIDTH-1:0]      = sync2_reg;
      ADDR_EDGE_CAP:   rd_word[WIDTH-1:0]      = edge_cap_reg;
      ADDR_IRQ_MASK:   rd_word[WIDTH-1:0]      = irq_mask_rd;
      ADDR_STATUS:     rd_word[STATUS_BUSY_BIT] = pulse_busy;
      default:         rd_word                 = '0;
    endcase
  end

  assign readdata = rd_word;

endmodule

// File: tb/tb_jaxa_pio_ctrl.sv
// tb_jaxa_pio_ctrl: directed self-checking bench for jaxa_pio_ctrl with
// WIDTH=8, PULSE_LEN=4, RESET_VALUE=8'hA5. Inputs are driven and outputs
// sampled around the falling clock edge.
`timescale 1ns/1ps

module tb_jaxa_pio_ctrl;

  localparam int          WIDTH     = 8;
  localparam int          PULSE_LEN = 4;
  localparam logic [7:0]  RST_VAL   = 8'hA5;
`ifdef JAXA_PIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  localparam logic [2:0] A_DATA  = 3'd0;
  localparam logic [2:0] A_SET   = 3'd1;
  localparam logic [2:0] A_CLR   = 3'd2;
  localparam logic [2:0] A_PMASK = 3'd3;
  localparam logic [2:0] A_IN    = 3'd4;
  localparam logic [2:0] A_EDGE  = 3'd5;
  localparam logic [2:0] A_IMASK = 3'd6;
  localparam logic [2:0] A_STAT  = 3'd7;

  logic             clk;
  logic             reset;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  int n_checks = 0;
  int n_fail   = 0;

  jaxa_pio_ctrl #(
    .WIDTH       (WIDTH),
    .PULSE_LEN   (PULSE_LEN),
    .RESET_VALUE (RST_VAL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .in_port    (in_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[%0t] FAIL %s: got 0x%08h, expected 0x%08h", $time, tag, obs, exp);
    end else begin
      $display("[%0t] ok   %s: 0x%08h", $time, tag, obs);
    end
  endtask

  task automatic drv_wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
  endtask

  task automatic drv_idle(input logic [2:0] a);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    writedata  = '0;
  endtask

  // One accepted write; returns at the falling edge after the accepting edge
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    drv_wr(a, d);
    @(negedge clk);
    drv_idle(a);
  endtask

  task automatic read_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    drv_idle(a);
    #1;
    check_val(tag, readdata, exp);
  endtask

  task automatic out_chk(input string tag, input logic [7:0] exp);
    check_val(tag, {24'h0, out_port}, {24'h0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;

    // ---------------- reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    out_chk("rst_out", RST_VAL);
    check_val("rst_irq", {31'h0, irq}, 32'h0);
    read_chk("rst_data", A_DATA, 32'h0000_00A5);
    read_chk("rst_pmask", A_PMASK, 32'h0);
    read_chk("rst_edge", A_EDGE, 32'h0);
    read_chk("rst_imask", A_IMASK, 32'h0);
    read_chk("rst_status", A_STAT, 32'h0);

    // ---------------- DATA / SET / CLEAR on successive edges
    @(negedge clk); drv_wr(A_DATA, 32'hFFFF_FF0F);
    @(negedge clk); #1 out_chk("data_0f", 8'h0F); drv_wr(A_SET, 32'h30);
    @(negedge clk); #1 out_chk("set_30", 8'h3F); drv_wr(A_CLR, 32'h05);
    @(negedge clk); #1 out_chk("clr_05", 8'h3A);
    read_chk("rd_set_zero", A_SET, 32'h0);
    read_chk("rd_clr_zero", A_CLR, 32'h0);
    read_chk("rd_data_3a", A_DATA, 32'h0000_003A);

    // ---------------- single pulse on bit0
    bus_write(A_PMASK, 32'h01);
    read_chk("pmask_rd", A_PMASK, 32'h01);
    out_chk("pmask_no_touch", 8'h3A);
    @(negedge clk); drv_wr(A_SET, 32'h01);          // accepted at edge N
    @(negedge clk); drv_idle(A_STAT); #1;
    out_chk("pulse_n1", 8'h3B);
    check_val("busy_n1", readdata, 32'h1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      out_chk($sformatf("pulse_n%0d", k + 1), 8'h3B);
      check_val($sformatf("busy_n%0d", k + 1), readdata, 32'h1);
    end
    @(negedge clk); #1;                              // after N+4
    out_chk("pulse_expired", 8'h3A);
    check_val("busy_cleared", readdata, 32'h0);

    // ---------------- retrigger at N+2 extends to N+6
    @(negedge clk); drv_wr(A_SET, 32'h01);          // N
    @(negedge clk); drv_idle(A_STAT);
    @(negedge clk); drv_wr(A_SET, 32'h01);          // N+2
    @(negedge clk); drv_idle(A_STAT); #1;
    out_chk("retrig_n2", 8'h3B);
    repeat (3) @(negedge clk);                       // after N+5
    #1 out_chk("retrig_n5", 8'h3B);
    check_val("retrig_busy_n5", readdata, 32'h1);
    @(negedge clk); #1;                              // after N+6
    out_chk("retrig_n6", 8'h3A);
    check_val("retrig_busy_n6", readdata, 32'h0);

    // ---------------- retrigger exactly on the expiry edge
    @(negedge clk); drv_wr(A_SET, 32'h01);          // N
    @(negedge clk); drv_idle(A_STAT);
    repeat (2) @(negedge clk);
    @(negedge clk); drv_wr(A_SET, 32'h01);          // N+4 (expiry edge)
    @(negedge clk); drv_idle(A_STAT); #1;
    out_chk("exp_retrig_n4", 8'h3B);
    check_val("exp_retrig_busy", readdata, 32'h1);
    repeat (3) @(negedge clk);                       // after N+7
    #1 out_chk("exp_retrig_n7", 8'h3B);
    @(negedge clk); #1 out_chk("exp_retrig_n8", 8'h3A);

    // ---------------- input synchroniser and edge capture
    bus_write(A_IMASK, 32'h08);
    read_chk("imask_rd", A_IMASK, IRQ_ON ? 32'h08 : 32'h0);
    @(negedge clk); in_port = 8'h08;                 // before E1
    @(negedge clk);                                  // after E1
    @(negedge clk); read_chk("edge_e2", A_EDGE, 32'h0);
    @(negedge clk); read_chk("edge_e3", A_EDGE, 32'h08);
    check_val("irq_e3", {31'h0, irq}, 32'h0);
    @(negedge clk); #1;
    check_val("irq_e4", {31'h0, irq}, IRQ_ON ? 32'h1 : 32'h0);
    read_chk("in_data", A_IN, 32'h08);
    bus_write(A_EDGE, 32'h08);
    read_chk("edge_w1c", A_EDGE, 32'h0);
    @(negedge clk); #1;
    check_val("irq_drop", {31'h0, irq}, 32'h0);

    // W1C coinciding with a new rising edge: set wins
    @(negedge clk); in_port = 8'h00;
    repeat (4) @(negedge clk);
    in_port = 8'h08;                                 // before E1
    @(negedge clk);                                  // after E1
    @(negedge clk); drv_wr(A_EDGE, 32'h08);          // accepted at E3
    @(negedge clk); read_chk("edge_set_wins", A_EDGE, 32'h08);

    // ---------------- reset asserted mid-pulse
    @(negedge clk); drv_wr(A_SET, 32'h01);          // N, pulse mask still 0x01
    @(negedge clk); drv_idle(A_STAT); #1;
    out_chk("mid_pulse_on", 8'h3B);
    @(negedge clk); reset = 1'b1;                    // count=2, reset at N+2
    @(negedge clk); reset = 1'b0; #1;
    out_chk("mid_rst_out", RST_VAL);
    check_val("mid_rst_busy", readdata, 32'h0);
    read_chk("mid_rst_pmask", A_PMASK, 32'h0);
    bus_write(A_DATA, 32'h02);
    repeat (4) @(negedge clk);
    drv_idle(A_STAT); #1;
    out_chk("post_rst_write", 8'h02);
    check_val("post_rst_busy", readdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
